multi_timer: RTL

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// multi_timer: N_CH independent hh:mm:ss channels (clock / stopwatch / countdown) on one shared prescaler.
// Optional feature macro MULTI_TIMER_ALARM_EN adds the channel-0 alarm (alarm_time / alarm ports).

module multi_timer_ch #(
    parameter logic [7:0] SW_HR = 8'd99
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        cmd_we,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_mode,
    input  logic [23:0] cmd_time,
    output logic [23:0] time_q,
    output logic [1:0]  mode_q,
    output logic        running,
    output logic        done,
    output logic        expire
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
    localparam logic [1:0]  OP_START = 2'd0, OP_STOP = 2'd1, OP_LOAD = 2'd2, OP_CLEAR = 2'd3;
    localparam logic [1:0]  M_CLK = 2'd0, M_SW = 2'd1, M_CD = 2'd2;
    localparam logic [23:0] SW_END = {SW_HR, 8'd59, 8'd59};

    state_e      state_q, state_d;
    logic [23:0] time_d, t_up, t_dn;
    logic [1:0]  mode_d;
    logic        exp_d;

    function automatic logic [23:0] t_inc(input logic [23:0] t, input logic wrap);
        logic [7:0] h, m, s;
        {h, m, s} = t;
        if (s < 8'd59) s = s + 8'd1;
        else begin
            s = 8'd0;
            if (m < 8'd59) m = m + 8'd1;
            else begin
                m = 8'd0;
                h = (wrap && h >= 8'd23) ? 8'd0 : h + 8'd1;
            end
        end
        return {h, m, s};
    endfunction

    function automatic logic [23:0] t_dec(input logic [23:0] t);
        logic [7:0] h, m, s;
        {h, m, s} = t;
        if (s != 8'd0) s = s - 8'd1;
        else begin
            s = 8'd59;
            if (m != 8'd0) m = m - 8'd1;
            else begin
                m = 8'd59;
                h = h - 8'd1;
            end
        end
        return {h, m, s};
    endfunction

    assign t_up    = t_inc(time_q, mode_q == M_CLK);
    assign t_dn    = t_dec(time_q);
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            time_q  <= '0;
            mode_q  <= M_CLK;
            expire  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            mode_q  <= mode_d;
            expire  <= exp_d;
        end
    end

    // Commands are pre-validated by the top; ticks never coincide with an accepted command.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        mode_d  = mode_q;
        exp_d   = expire;
        if (cmd_we) begin
            case (cmd_op)
                OP_START: if (state_q == IDLE || state_q == PAUSE) begin
                    if (mode_q == M_CD && time_q == 24'd0) begin
                        state_d = DONE;
                        exp_d   = 1'b1;
                    end else state_d = RUN;
                end
                OP_STOP:  state_d = PAUSE;
                OP_LOAD: begin
                    state_d = IDLE;
                    time_d  = cmd_time;
                    mode_d  = cmd_mode;
                    exp_d   = 1'b0;
                end
                OP_CLEAR: begin
                    state_d = IDLE;
                    time_d  = '0;
                    exp_d   = 1'b0;
                end
            endcase
        end else if (tick && state_q == RUN) begin
            case (mode_q)
                M_CLK: time_d = t_up;
                M_SW: begin
                    if (time_q < SW_END) time_d = t_up;
                    if (time_q >= SW_END || t_up == SW_END) begin
                        state_d = DONE;
                        exp_d   = 1'b1;
                    end
                end
                M_CD: begin
                    if (time_q != 24'd0) time_d = t_dn;
                    if (time_q == 24'd0 || t_dn == 24'd0) begin
                        state_d = DONE;
                        exp_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module multi_timer #(
    parameter  int N_CH      = 4,
    parameter  int TICK_DIV  = 1000,
    parameter  int SW_MAX_HR = 99,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [1:0]        cmd_mode,
    input  logic [23:0]       cmd_time,
    output logic              cmd_err,
    input  logic              time_format,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [23:0]       rd_time,
    output logic              rd_valid,
    output logic [N_CH-1:0]   running,
`ifdef MULTI_TIMER_ALARM_EN
    input  logic [23:0]       alarm_time,
    output logic              alarm,
`endif
    output logic [N_CH-1:0]   expire
);
    localparam int         PS_W  = $clog2(TICK_DIV);
    localparam int         NP    = 1 << CH_W;
    localparam logic [7:0] SW_HR = 8'(SW_MAX_HR);
    localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1, OP_LOAD = 2'd2;
    localparam logic [1:0] M_CLK = 2'd0, M_SW = 2'd1;

    logic [PS_W-1:0]         ps_cnt;
    logic                    tick, cmd_acc, cmd_bad, cmd_go, load_bad;
    logic [N_CH-1:0][23:0]   ch_time;
    logic [N_CH-1:0][1:0]    ch_mode;
    logic [N_CH-1:0]         ch_done;
    logic [NP-1:0]           ok_pad, run_pad, done_pad;
    logic [NP-1:0][23:0]     disp_pad;

    function automatic logic [23:0] disp12(input logic [23:0] t);
        logic [7:0] h;
        h = t[23:16];
        if (h == 8'd0) h = 8'd12;
        else if (h > 8'd12) h = h - 8'd12;
        return {h, t[15:0]};
    endfunction

    assign tick      = (ps_cnt == PS_W'(TICK_DIV - 1));
    assign cmd_ready = !tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ps_cnt <= '0;
        else        ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
    end

    assign load_bad = (cmd_time[7:0] > 8'd59) || (cmd_time[15:8] > 8'd59) || (cmd_mode == 2'b11) ||
                      ((cmd_mode == M_SW) ? (cmd_time[23:16] > SW_HR) : (cmd_time[23:16] > 8'd23));
    assign cmd_bad  = !ok_pad[cmd_ch] ||
                      (cmd_op == OP_START && done_pad[cmd_ch]) ||
                      (cmd_op == OP_STOP  && !run_pad[cmd_ch]) ||
                      (cmd_op == OP_LOAD  && load_bad);
    assign cmd_acc  = cmd_valid && cmd_ready;
    assign cmd_go   = cmd_acc && !cmd_bad;

    // Channel slots are padded to a power of two so out-of-range selects read as absent/zero.
    for (genvar i = 0; i < NP; i++) begin : g_ch
        if (i < N_CH) begin : g_on
            multi_timer_ch #(.SW_HR(SW_HR)) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .tick     (tick),
                .cmd_we   (cmd_go && (cmd_ch == CH_W'(i))),
                .cmd_op   (cmd_op),
                .cmd_mode (cmd_mode),
                .cmd_time (cmd_time),
                .time_q   (ch_time[i]),
                .mode_q   (ch_mode[i]),
                .running  (running[i]),
                .done     (ch_done[i]),
                .expire   (expire[i])
            );
            assign ok_pad[i]   = 1'b1;
            assign run_pad[i]  = running[i];
            assign done_pad[i] = ch_done[i];
            assign disp_pad[i] = (time_format && ch_mode[i] == M_CLK) ? disp12(ch_time[i]) : ch_time[i];
        end else begin : g_off
            assign ok_pad[i]   = 1'b0;
            assign run_pad[i]  = 1'b0;
            assign done_pad[i] = 1'b0;
            assign disp_pad[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err  <= 1'b0;
            rd_valid <= 1'b0;
            rd_time  <= '0;
        end else begin
            cmd_err  <= cmd_acc && cmd_bad;
            rd_valid <= tick || cmd_acc;
            rd_time  <= disp_pad[rd_ch];
        end
    end

`ifdef MULTI_TIMER_ALARM_EN
    logic tick_q;

    // Compare one cycle after the tick so the freshly advanced time of channel 0 is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            alarm  <= 1'b0;
        end else begin
            tick_q <= tick;
            if (cmd_acc && cmd_ch == '0)
                alarm <= 1'b0;
            else if (tick_q && running[0] && ch_mode[0] == M_CLK && ch_time[0] == alarm_time)
                alarm <= 1'b1;
        end
    end
`endif
endmodule
